ir_fetch_cache: RTL and testbench
=================================

IR_FETCH_CACHE -- requirements
Module: ir_fetch_cache

Interface
REQ-001 Parameter DATA_WIDTH, 8, instruction/operand word width.
REQ-002 Parameter ADDR_WIDTH, 16, instruction address width.
REQ-003 Parameter LINE_WORDS, 64, cache line depth in words; power of two; OFF_W = log2(LINE_WORDS).
REQ-004 clk  in  1  clock; all state updates on the rising edge.
REQ-005 rst_n  in  1  reset, synchronous, active-low.
REQ-006 irp  in  ADDR_WIDTH  instruction pointer from the downstream ir_decoder.
REQ-007 ir_data  out  DATA_WIDTH  word at irp, registered; feeds decoder data_in.
REQ-008 ir_valid  out  1  ir_data holds the word for the irp sampled on the previous cycle.
REQ-009 cash_init_load_finished  out  1  sticky level; first line fill done.
REQ-010 mem_req  out  1  external memory read request.
REQ-011 mem_addr  out  ADDR_WIDTH  external read address.
REQ-012 mem_ack  in  1  mem_rdata valid for current mem_addr.
REQ-013 mem_rdata  in  DATA_WIDTH  external read data.
REQ-014 busy  out  1  high while in FILL.

Function
REQ-015 Storage: LINE_WORDS x DATA_WIDTH buffer; tag register of ADDR_WIDTH-OFF_W bits; tag_valid bit.
REQ-016 FSM states: IDLE, FILL, READY; each state held until its exit condition.
REQ-017 IDLE: entered on reset; next cycle -> FILL with line base 0x0000, fill_idx = 0.
REQ-018 FILL: mem_req = 1; mem_addr = {base_tag, fill_idx}; mem_addr stable until the acked cycle.
REQ-019 FILL: on mem_ack = 1, write mem_rdata to buf[fill_idx]; fill_idx increments by 1.
REQ-020 mem_ack while mem_req = 0 ignored; no write, no increment.
REQ-021 Ack with fill_idx = LINE_WORDS-1: next state READY; tag <= base_tag; tag_valid <= 1; fill_idx wraps to 0.
REQ-022 mem_req low on the cycle after the last ack.
REQ-023 cash_init_load_finished rises on the cycle after the first fill completes; stays high until reset.
REQ-024 READY hit: irp[ADDR_WIDTH-1:OFF_W] == tag and tag_valid.
REQ-025 On a hit: next cycle ir_data = buf[irp[OFF_W-1:0]] and ir_valid = 1; one-cycle latency; back-to-back hits every cycle.
REQ-026 READY miss: next cycle ir_valid = 0 and ir_data holds its last value.
REQ-027 Miss: base_tag <= irp[ADDR_WIDTH-1:OFF_W]; tag_valid <= 0; -> FILL.
REQ-028 FILL ignores irp; ir_valid = 0 throughout FILL.
REQ-029 First READY cycle after FILL re-evaluates the current irp (hit or miss).
REQ-030 Offset LINE_WORDS-1 -> 0 with tag change (line wrap) is a miss.
REQ-031 irp = 0xFFFF -> 0x0000 is a miss unless the resident tag is 0.
REQ-032 Ack in the same cycle irp changes during FILL: ack consumed normally; irp change has no effect.
REQ-033 busy = 1 exactly when state == FILL.

Reset
REQ-034 rst_n = 0 at a clock edge: state IDLE, fill_idx 0, tag 0, tag_valid 0.
REQ-035 Same reset: ir_data 0, ir_valid 0, cash_init_load_finished 0, mem_req 0, mem_addr 0, busy 0.
REQ-036 Reset mid-FILL aborts the fill; the partial line is discarded; the next fill starts again at base 0x0000.
REQ-037 Buffer contents need not be cleared on reset.

Verification
REQ-038 Release reset; memory returns data = address[7:0] with ack every cycle.
  -> mem_addr 0x0000..0x003F, 64 acks; cash_init_load_finished rises 1 cycle after the 64th ack.
REQ-039 After init, irp = 0x0005 then 0x0006 on consecutive cycles.
  -> ir_data 0x05 then 0x06, ir_valid = 1 each cycle, latency 1.
REQ-040 irp = 0x0040 (miss).
  -> ir_valid = 0; busy = 1; mem_addr 0x0040..0x007F; then ir_data 0x40, ir_valid = 1.
REQ-041 Memory with random ack gaps (0-3 idle cycles); mem_ack pulsed while mem_req = 0.
  -> mem_addr held steady until acked; stray acks do not write; buffer contents correct.
REQ-042 rst_n low after the 20th ack of a fill.
  -> all outputs at reset values; the next fill restarts at mem_addr 0x0000; cash_init_load_finished = 0 until it completes.
REQ-043 irp toggles between 0x003F and 0x0040.
  -> each change is a miss and triggers a full refill; returned data correct every time.

Source files
------------

// File: rtl/ir_fetch_cache.sv
// ir_fetch_cache: single-line instruction fetch cache in front of an external
// word-wide memory. A line of LINE_WORDS words is filled from memory after
// reset and on every miss; hits return the word one cycle after irp is sampled.
module ir_fetch_cache #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 16,
  parameter int LINE_WORDS = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] irp,
  output logic [DATA_WIDTH-1:0] ir_data,
  output logic                  ir_valid,
  output logic                  cash_init_load_finished,
  output logic                  mem_req,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic                  mem_ack,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  busy
);

  localparam int OFF_W = $clog2(LINE_WORDS);
  localparam int TAG_W = ADDR_WIDTH - OFF_W;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    READY
  } state_t;

  state_t                state;
  logic [DATA_WIDTH-1:0] line_buf [LINE_WORDS];
  logic [TAG_W-1:0]      tag;
  logic [TAG_W-1:0]      base_tag;
  logic                  tag_valid;
  logic [OFF_W-1:0]      fill_idx;

  logic [TAG_W-1:0]      irp_tag;
  logic [OFF_W-1:0]      irp_off;
  logic                  hit;
  logic                  fill_write;

  assign irp_tag    = irp[ADDR_WIDTH-1:OFF_W];
  assign irp_off    = irp[OFF_W-1:0];
  assign hit        = tag_valid && (irp_tag == tag);
  // mem_req is high exactly in FILL, so stray acks outside a fill never write
  assign fill_write = mem_req && mem_ack;
  // base_tag and fill_idx only move on an acked cycle, keeping the address stable
  assign mem_addr   = {base_tag, fill_idx};

  // Line buffer write port; contents are not cleared by reset
  always_ff @(posedge clk) begin
    if (fill_write) begin
      line_buf[fill_idx] <= mem_rdata;
    end
  end

  // Fetch FSM: line fill sequencing, tag bookkeeping and registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state                   <= IDLE;
      fill_idx                <= '0;
      tag                     <= '0;
      base_tag                <= '0;
      tag_valid               <= 1'b0;
      ir_data                 <= '0;
      ir_valid                <= 1'b0;
      cash_init_load_finished <= 1'b0;
      mem_req                 <= 1'b0;
      busy                    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          base_tag <= '0;
          fill_idx <= '0;
          ir_valid <= 1'b0;
          mem_req  <= 1'b1;
          busy     <= 1'b1;
          state    <= FILL;
        end
        FILL: begin
          ir_valid <= 1'b0;
          if (mem_ack) begin
            fill_idx <= fill_idx + OFF_W'(1);
            if (fill_idx == OFF_W'(LINE_WORDS - 1)) begin
              tag                     <= base_tag;
              tag_valid               <= 1'b1;
              cash_init_load_finished <= 1'b1;
              mem_req                 <= 1'b0;
              busy                    <= 1'b0;
              state                   <= READY;
            end
          end
        end
        READY: begin
          if (hit) begin
            ir_data  <= line_buf[irp_off];
            ir_valid <= 1'b1;
          end else begin
            ir_valid  <= 1'b0;
            base_tag  <= irp_tag;
            tag_valid <= 1'b0;
            fill_idx  <= '0;
            mem_req   <= 1'b1;
            busy      <= 1'b1;
            state     <= FILL;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ir_fetch_cache.sv
// tb_ir_fetch_cache: drives ir_fetch_cache with a table of hit vectors,
// hand-written miss / reset sequences and randomized lookups against a
// line-level model of the cache and a simple memory responder.
module tb_ir_fetch_cache;

  localparam int AW = 16;
  localparam int DW = 8;
  localparam int LW = 64;
  localparam int OW = 6;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [AW-1:0] irp;
  logic [DW-1:0] ir_data;
  logic          ir_valid;
  logic          cash_init_load_finished;
  logic          mem_req;
  logic [AW-1:0] mem_addr;
  logic          mem_ack;
  logic [DW-1:0] mem_rdata;
  logic          busy;

  ir_fetch_cache #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW),
    .LINE_WORDS(LW)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .irp(irp),
    .ir_data(ir_data),
    .ir_valid(ir_valid),
    .cash_init_load_finished(cash_init_load_finished),
    .mem_req(mem_req),
    .mem_addr(mem_addr),
    .mem_ack(mem_ack),
    .mem_rdata(mem_rdata),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // memory / model state
  bit            mode = 1'b0;
  int unsigned   gap_max = 0;
  int unsigned   gap_left = 0;
  bit            stray_en = 1'b0;
  bit            prev_pending = 1'b0;
  logic [AW-1:0] prev_addr = '0;
  logic [AW-OW-1:0] fill_base = '0;
  int            ack_cnt = 0;
  bit            model_valid = 1'b0;
  logic [AW-OW-1:0] model_tag = '0;
  bit            init_done = 1'b0;
  logic [DW-1:0] last_data = '0;

  typedef struct {
    logic [AW-1:0] irp;
    logic          valid;
    logic [DW-1:0] data;
  } vec_t;
  vec_t vecs [6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] mem_fn(input logic [AW-1:0] a);
    logic [7:0] hi;
    hi = a[15:8];
    if (mode) return a[7:0] ^ 8'(hi * 8'h1D);
    return a[7:0];
  endfunction

  // Memory responder: random ack gaps while requested, stray acks otherwise
  always @(posedge clk) begin
    #2;
    if (!rst_n) begin
      mem_ack      = 1'b0;
      prev_pending = 1'b0;
    end else if (mem_req) begin
      if (prev_pending) chk("addr_hold", 32'(mem_addr), 32'(prev_addr));
      if (gap_left == 0) begin
        chk("fill_addr", 32'(mem_addr), 32'({fill_base, 6'(ack_cnt)}));
        mem_ack      = 1'b1;
        mem_rdata    = mem_fn(mem_addr);
        ack_cnt++;
        gap_left     = $urandom_range(0, gap_max);
        prev_pending = 1'b0;
      end else begin
        gap_left--;
        mem_ack      = 1'b0;
        prev_pending = 1'b1;
        prev_addr    = mem_addr;
      end
    end else begin
      prev_pending = 1'b0;
      mem_ack      = stray_en && ($urandom_range(0, 1) == 1);
      mem_rdata    = 8'($urandom);
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
    $fatal(1, "watchdog");
  end

  // called at the first negedge of a fill (busy expected high)
  task automatic wait_fill();
    int n;
    n = 0;
    while (busy === 1'b1 && n < 1000) begin
      chk("init_flag_during_fill", 32'(cash_init_load_finished), 32'(init_done));
      @(negedge clk);
      n++;
    end
    chk("fill_timeout", 32'(busy), 0);
    chk("fill_ack_count", 32'(ack_cnt), LW);
    chk("mem_req_after_fill", 32'(mem_req), 0);
    init_done = 1'b1;
    chk("init_flag_set", 32'(cash_init_load_finished), 1);
    chk("valid_after_fill", 32'(ir_valid), 0);
  endtask

  task automatic do_reset();
    rst_n       = 1'b0;
    irp         = '0;
    fill_base   = '0;
    ack_cnt     = 0;
    model_valid = 1'b0;
    init_done   = 1'b0;
    last_data   = '0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_ir_data", 32'(ir_data), 0);
    chk("rst_ir_valid", 32'(ir_valid), 0);
    chk("rst_init_flag", 32'(cash_init_load_finished), 0);
    chk("rst_mem_req", 32'(mem_req), 0);
    chk("rst_mem_addr", 32'(mem_addr), 0);
    chk("rst_busy", 32'(busy), 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("restart_busy", 32'(busy), 1);
    chk("restart_addr", 32'(mem_addr), 0);
    wait_fill();
    model_tag   = '0;
    model_valid = 1'b1;
  endtask

  // present address a; follows misses and refills until a hit is returned
  task automatic serve(input logic [AW-1:0] a, input bit disturb);
    logic [AW-1:0] cur;
    bit hit;
    bit dis;
    cur = a;
    dis = disturb;
    irp = cur;
    for (int it = 0; it < 3; it++) begin
      hit = model_valid && (cur[AW-1:OW] == model_tag);
      if (!hit) begin
        fill_base   = cur[AW-1:OW];
        ack_cnt     = 0;
        model_valid = 1'b0;
      end
      @(negedge clk);
      if (hit) begin
        chk("hit_valid", 32'(ir_valid), 1);
        chk("hit_data", 32'(ir_data), 32'(mem_fn(cur)));
        last_data = mem_fn(cur);
        return;
      end
      chk("miss_valid", 32'(ir_valid), 0);
      chk("miss_hold_data", 32'(ir_data), 32'(last_data));
      chk("miss_busy", 32'(busy), 1);
      if (dis) begin
        cur = {10'($urandom_range(0, 3) * 341), 6'($urandom_range(0, 63))};
        irp = cur;
        dis = 1'b0;
      end
      wait_fill();
      model_tag   = fill_base;
      model_valid = 1'b1;
    end
    chk("serve_converged", 32'(ir_valid), 1);
  endtask

  initial begin
    logic [AW-1:0] a;
    int n;
    rst_n     = 1'b0;
    irp       = '0;
    mem_ack   = 1'b0;
    mem_rdata = '0;

    vecs[0] = '{16'h0005, 1'b1, 8'h05};
    vecs[1] = '{16'h0006, 1'b1, 8'h06};
    vecs[2] = '{16'h003F, 1'b1, 8'h3F};
    vecs[3] = '{16'h0000, 1'b1, 8'h00};
    vecs[4] = '{16'h0021, 1'b1, 8'h21};
    vecs[5] = '{16'h0021, 1'b1, 8'h21};

    // reset values and initial fill of line 0, ack every cycle
    do_reset();

    // back-to-back hits from the table
    foreach (vecs[i]) begin
      irp = vecs[i].irp;
      @(negedge clk);
      chk("tbl_valid", 32'(ir_valid), 32'(vecs[i].valid));
      chk("tbl_data", 32'(ir_data), 32'(vecs[i].data));
      last_data = vecs[i].data;
    end

    // miss into the next line
    serve(16'h0040, 1'b0);
    serve(16'h0041, 1'b0);

    // line-wrap toggling, each change refills
    for (int i = 0; i < 3; i++) begin
      serve(16'h003F, 1'b0);
      serve(16'h0040, 1'b0);
    end

    // top of address space wrapping to zero
    serve(16'hFFFF, 1'b0);
    serve(16'h0000, 1'b0);

    // reset after the 20th ack of a fill
    irp         = 16'h0080;
    fill_base   = 10'h002;
    ack_cnt     = 0;
    model_valid = 1'b0;
    @(negedge clk);
    chk("abort_fill_busy", 32'(busy), 1);
    n = 0;
    while (ack_cnt < 20 && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("abort_ack_count", 32'(ack_cnt), 20);
    @(negedge clk);
    chk("abort_init_flag_before", 32'(cash_init_load_finished), 1);
    do_reset();

    // randomized lookups with ack gaps and stray acks
    mode     = 1'b1;
    gap_max  = 3;
    stray_en = 1'b1;
    for (int i = 0; i < 40; i++) begin
      a = {10'($urandom_range(0, 3) * 341), 6'($urandom_range(0, 63))};
      if ($urandom_range(0, 3) == 0) a[AW-1:OW] = 10'h001;
      serve(a, $urandom_range(0, 3) == 0);
      for (int k = 0; k < int'($urandom_range(0, 3)); k++) begin
        serve({a[AW-1:OW], 6'($urandom_range(0, 63))}, 1'b0);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
